// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and channel response type.
// Latency: n/a (no logic).
// Backpressure: n/a.
package axi4lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4lite_wr_buf.sv
// AXI4-Lite write-side staging: one-entry AW and W buffers filled independently.
// Latency: commit strobe the cycle after both buffers hold an entry (no B pending).
// Backpressure: AW/W ready drop while their buffer is full or a B response is pending.
module axi4lite_wr_buf #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  input  logic                bvalid_i,
  output logic                commit_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   data_o,
  output logic [DATA_W/8-1:0] strb_o
);

  logic                aw_full_q, aw_full_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic                w_full_q, w_full_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [DATA_W/8-1:0] w_strb_q, w_strb_d;

  // Readiness and commit depend only on buffer state and the pending response.
  always_comb begin
    awready_o = !aw_full_q && !bvalid_i;
    wready_o  = !w_full_q && !bvalid_i;
    commit_o  = aw_full_q && w_full_q && !bvalid_i;
    addr_o    = aw_addr_q;
    data_o    = w_data_q;
    strb_o    = w_strb_q;
  end

  // Buffer fill on handshake, drain on commit (never both in one cycle).
  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    if (commit_o) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
    if (awvalid_i && awready_o) begin
      aw_full_d = 1'b1;
      aw_addr_d = awaddr_i;
    end
    if (wvalid_i && wready_o) begin
      w_full_d = 1'b1;
      w_data_d = wdata_i;
      w_strb_d = wstrb_i;
    end
  end

  // Buffer state registers; reset discards any staged beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
    end
  end

endmodule

// File: rtl/axi4lite_regbank.sv
// Parametrised AXI4-Lite register bank with byte strobes, RO status registers and SLVERR decode.
// Latency: B two cycles after the later AW/W handshake; R one cycle after the AR handshake.
// Backpressure: one outstanding write and one outstanding read; ready held low until B/R accepted.
module axi4lite_regbank
  import axi4lite_pkg::*;
#(
  parameter int                  DATA_W   = 8,
  parameter int                  ADDR_W   = 2,
  parameter int                  NUM_REGS = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                       s_axi_aclk,
  input  logic                       s_axi_areset,
  input  logic [ADDR_W-1:0]          s_axi_awaddr,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [DATA_W-1:0]          s_axi_wdata,
  input  logic [DATA_W/8-1:0]        s_axi_wstrb,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [ADDR_W-1:0]          s_axi_araddr,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [DATA_W-1:0]          s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  input  logic [NUM_REGS*DATA_W-1:0] hw_status_i,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam int NUM_LANES = DATA_W / 8;

  logic                       commit;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic [NUM_LANES-1:0]       wr_strb;

  logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
  logic                       bvalid_q, bvalid_d;
  resp_t                      bresp_q, bresp_d;
  logic                       rvalid_q, rvalid_d;
  resp_t                      rresp_q, rresp_d;
  logic [DATA_W-1:0]          rdata_q, rdata_d;

  logic                       wr_hit;
  logic                       ar_hs;
  logic [DATA_W-1:0]          rd_val;
  resp_t                      rd_resp;

  axi4lite_wr_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_buf (
    .clk_i     (s_axi_aclk),
    .rst_i     (s_axi_areset),
    .awaddr_i  (s_axi_awaddr),
    .awvalid_i (s_axi_awvalid),
    .awready_o (s_axi_awready),
    .wdata_i   (s_axi_wdata),
    .wstrb_i   (s_axi_wstrb),
    .wvalid_i  (s_axi_wvalid),
    .wready_o  (s_axi_wready),
    .bvalid_i  (bvalid_q),
    .commit_o  (commit),
    .addr_o    (wr_addr),
    .data_o    (wr_data),
    .strb_o    (wr_strb)
  );

  // Strobed merge into the addressed RW register; RO and unmapped targets are ignored.
  always_comb begin
    regs_d = regs_q;
    wr_hit = 1'b0;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (wr_addr == ADDR_W'(n)) begin
        wr_hit = 1'b1;
        if (commit && !RO_MASK[n]) begin
          for (int k = 0; k < NUM_LANES; k++) begin
            if (wr_strb[k]) begin
              regs_d[n*DATA_W + k*8 +: 8] = wr_data[k*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Write response: raised on commit, held until accepted.
  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && s_axi_bready) begin
      bvalid_d = 1'b0;
    end
  end

  // Read decode from the current (pre-commit) register state or the RO status inputs.
  always_comb begin
    rd_val  = '0;
    rd_resp = RESP_SLVERR;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (s_axi_araddr == ADDR_W'(n)) begin
        rd_resp = RESP_OKAY;
        rd_val  = RO_MASK[n] ? hw_status_i[n*DATA_W +: DATA_W] : regs_q[n*DATA_W +: DATA_W];
      end
    end
  end

  // Read channel: load on AR handshake, hold until accepted.
  always_comb begin
    ar_hs    = s_axi_arvalid && !rvalid_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_resp;
      rdata_d  = rd_val;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // Register array and response channel state.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      regs_q   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      regs_q   <= regs_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_arready = !rvalid_q;
  assign regs_o        = regs_q;

endmodule
